// File: rtl/uart_tx_fifo_if.sv
// Byte-stream handshake into the UART transmitter: a byte moves on any rising
// edge where in_valid && in_ready; the producer holds in_data stable while waiting.
interface uart_tx_fifo_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; ena=0 freezes the whole block.
// Frames run back-to-back: the stop-bit end pops the next byte straight into START.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    uart_tx_fifo_if.slave                 s_in,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_tx;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_timer_end;
    logic            w_empty;
    logic            w_full;
    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_head;

    assign w_timer_end = (r_timer == TW'(CLKS_PER_BIT - 1));
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
    // Readiness looks only at the current count, so a pop never frees a slot for the same edge.
    assign w_ready     = !w_full && ena;
    assign w_push      = s_in.in_valid && w_ready;
    assign w_pop       = ena && !w_empty &&
                         ((r_state == S_IDLE) || (r_state == S_STOP && w_timer_end));
    assign w_head      = r_mem[r_rd_ptr];

    assign s_in.in_ready = w_ready;
    assign tx            = r_tx;
    assign busy          = (r_state != S_IDLE);
    assign fifo_count    = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_in.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_timer <= '0;
                    end
                end
                S_START: begin
                    if (w_timer_end) begin
                        r_timer <= '0;
                        r_idx   <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (w_timer_end) begin
                        r_timer <= '0;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_STOP: begin
                    if (w_timer_end) begin
                        r_timer <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized checks of uart_tx_fifo; two instances cover bit periods of 4 and 8 clocks.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena4 = 1'b1;
    logic ena8 = 1'b1;
    logic tx4, busy4, tx8, busy8;
    logic [2:0] cnt4, cnt8;

    uart_tx_fifo_if bus4 ();
    uart_tx_fifo_if bus8 ();

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena4), .s_in(bus4),
        .tx(tx4), .busy(busy4), .fifo_count(cnt4));
    uart_tx_fifo #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena8), .s_in(bus8),
        .tx(tx8), .busy(busy8), .fifo_count(cnt8));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int mism, hi_cnt, busy_cnt, p, n_acc, fl, rx_pos, rx_cnt, n_pop;
    int acc [6];
    logic rdy, vld, prev_tx, e, v, m_ready, exp_bit;
    logic [7:0] d, rx_byte, exp_byte;
    logic [7:0] q_model [$];
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line level at offset k (in clocks) from the start of a single frame.
    function automatic logic exp_tx(input logic [7:0] b, input int k, input int cpb);
        int bi;
        bi = k / cpb;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
        return 1'b1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus4.in_valid = 1'b0; bus4.in_data = 8'h00;
        bus8.in_valid = 1'b0; bus8.in_data = 8'h00;

        // Reset state and idle line
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_tx", 32'(tx4), 32'd1);
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_count", 32'(cnt4), 32'd0);
        chk("rst_ready", 32'(bus4.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mism = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx4 !== 1'b1 || busy4 !== 1'b0) mism++;
        end
        chk("idle_20", 32'(mism), 32'd0);

        // Single frame 0xA5 at 4 clocks per bit
        bus4.in_data = 8'hA5; bus4.in_valid = 1'b1;
        step();
        bus4.in_valid = 1'b0;
        chk("a5_count_after_push", 32'(cnt4), 32'd1);
        chk("a5_tx_after_push", 32'(tx4), 32'd1);
        mism = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (tx4 !== exp_tx(8'hA5, k, 4) || busy4 !== 1'b1) mism++;
        end
        chk("a5_wave", 32'(mism), 32'd0);
        step();
        chk("a5_busy_fall", 32'(busy4), 32'd0);
        chk("a5_tx_idle", 32'(tx4), 32'd1);

        // Back-to-back bytes 0x01..0x06 with in_valid held
        n_acc = 0; mism = 0;
        bus4.in_data = 8'h01; bus4.in_valid = 1'b1;
        for (int c = 1; c <= 250; c++) begin
            rdy = bus4.in_ready; vld = bus4.in_valid;
            step();
            if (rdy && vld && n_acc < 6) begin
                acc[n_acc] = c;
                n_acc++;
                if (n_acc == 6) bus4.in_valid = 1'b0;
                else bus4.in_data = 8'(n_acc + 1);
            end
            if (c >= 2 && c < 242)
                exp_bit = exp_tx(8'((c - 2) / 40 + 1), (c - 2) % 40, 4);
            else
                exp_bit = 1'b1;
            if (tx4 !== exp_bit) mism++;
            if (c == 5) begin
                chk("b2b_ready_full", 32'(bus4.in_ready), 32'd0);
                chk("b2b_count_full", 32'(cnt4), 32'd4);
            end
            if (c == 241) chk("b2b_busy_last", 32'(busy4), 32'd1);
            if (c == 242) chk("b2b_busy_done", 32'(busy4), 32'd0);
        end
        bus4.in_valid = 1'b0;
        chk("b2b_wave", 32'(mism), 32'd0);
        chk("b2b_n_acc", 32'(n_acc), 32'd6);
        chk("b2b_acc0", 32'(acc[0]), 32'd1);
        chk("b2b_acc4", 32'(acc[4]), 32'd5);
        chk("b2b_acc5", 32'(acc[5]), 32'd43);

        // Freeze with ena low for 7 cycles during data bit 2 of 0x3C
        bus8.in_data = 8'h3C; bus8.in_valid = 1'b1;
        step();
        bus8.in_valid = 1'b0;
        step();
        p = 0; mism = 0; hi_cnt = 0; busy_cnt = 0;
        if (tx8 !== 1'b0) mism++;
        if (busy8 === 1'b1) busy_cnt++;
        prev_tx = tx8;
        for (int s = 1; s <= 86; s++) begin
            ena8 = !(s >= 28 && s <= 34);
            bus8.in_valid = !ena8;
            bus8.in_data = 8'h99;
            if (s == 30) begin
                #1;
                chk("frz_ready", 32'(bus8.in_ready), 32'd0);
            end
            step();
            if (ena8) p++;
            if (!ena8 && tx8 !== prev_tx) mism++;
            if (tx8 !== exp_tx(8'h3C, p, 8)) mism++;
            if (tx8 === 1'b1) hi_cnt++;
            if (busy8 === 1'b1) busy_cnt++;
            prev_tx = tx8;
            if (s == 35) chk("frz_no_push", 32'(cnt8), 32'd0);
        end
        ena8 = 1'b1; bus8.in_valid = 1'b0;
        chk("frz_wave", 32'(mism), 32'd0);
        chk("frz_high_samples", 32'(hi_cnt), 32'd47);
        chk("frz_frame_len", 32'(busy_cnt), 32'd87);
        step();
        chk("frz_busy_fall", 32'(busy8), 32'd0);

        // Reset in the middle of data bit 4 of the first of three queued bytes
        bus4.in_valid = 1'b1; bus4.in_data = 8'h0F;
        step();
        bus4.in_data = 8'h55;
        step();
        bus4.in_data = 8'hAA;
        step();
        bus4.in_valid = 1'b0;
        chk("mrst_count_q", 32'(cnt4), 32'd2);
        for (int c = 4; c <= 23; c++) step();
        chk("mrst_tx_before", 32'(tx4), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_tx", 32'(tx4), 32'd1);
        chk("mrst_count", 32'(cnt4), 32'd0);
        chk("mrst_busy", 32'(busy4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mism = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx4 !== 1'b1 || busy4 !== 1'b0 || cnt4 !== 3'd0) mism++;
        end
        chk("mrst_quiet_100", 32'(mism), 32'd0);

        // 0xFF, then 0x00 pushed during the last stop-bit cycle
        bus4.in_data = 8'hFF; bus4.in_valid = 1'b1;
        step();
        bus4.in_valid = 1'b0;
        mism = 0;
        for (int k = 0; k < 39; k++) begin
            step();
            if (tx4 !== exp_tx(8'hFF, k, 4)) mism++;
        end
        bus4.in_data = 8'h00; bus4.in_valid = 1'b1;
        step();
        bus4.in_valid = 1'b0;
        if (tx4 !== 1'b1) mism++;
        chk("gap_count", 32'(cnt4), 32'd1);
        step();
        chk("gap_start_tx", 32'(tx4), 32'd0);
        chk("gap_start_busy", 32'(busy4), 32'd1);
        for (int k = 1; k < 40; k++) begin
            step();
            if (tx4 !== exp_tx(8'h00, k, 4) || busy4 !== 1'b1) mism++;
        end
        chk("gap_wave", 32'(mism), 32'd0);
        step();
        chk("gap_busy_fall", 32'(busy4), 32'd0);

        // Randomized traffic with ena gaps against a queue model and a line receiver
        q_model.delete(); exp_q.delete();
        fl = 0; rx_pos = -1; rx_cnt = 0; n_pop = 0; rx_byte = 8'h00;
        for (int cyc = 0; cyc < 1900; cyc++) begin
            if (cyc < 1500) begin
                e = ($urandom_range(0, 9) != 0);
                v = 1'($urandom_range(0, 1));
            end else begin
                e = 1'b1;
                v = 1'b0;
            end
            d = 8'($urandom_range(0, 255));
            ena4 = e; bus4.in_valid = v; bus4.in_data = d;
            #1;
            m_ready = (q_model.size() < 4) && e;
            chk("rnd_ready", 32'(bus4.in_ready), 32'(m_ready));
            step();
            // Model: a frame is 40 enabled edges; its last edge may start the next one.
            if (e) begin
                if ((fl == 0 || fl == 1) && q_model.size() > 0) begin
                    exp_q.push_back(q_model.pop_front());
                    n_pop++;
                    fl = 40;
                end else if (fl > 0) begin
                    fl--;
                end
                if (m_ready && v) q_model.push_back(d);
            end
            chk("rnd_count", 32'(cnt4), 32'(q_model.size()));
            chk("rnd_busy", 32'(busy4), 32'(fl > 0));
            if (e) begin
                if (rx_pos >= 0) rx_pos++;
                if (rx_pos >= 40) rx_pos = -1;
                if (rx_pos < 0 && tx4 === 1'b0) rx_pos = 0;
                if (rx_pos >= 0 && (rx_pos % 4) == 2) begin
                    if (rx_pos / 4 == 0) begin
                        chk("rnd_start_bit", 32'(tx4), 32'd0);
                    end else if (rx_pos / 4 <= 8) begin
                        rx_byte[rx_pos / 4 - 1] = tx4;
                    end else begin
                        chk("rnd_stop_bit", 32'(tx4), 32'd1);
                        chk("rnd_rx_underflow", 32'(exp_q.size() > 0), 32'd1);
                        exp_byte = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                        chk("rnd_rx_byte", 32'(rx_byte), 32'(exp_byte));
                        rx_cnt++;
                    end
                end
            end
        end
        chk("rnd_all_received", 32'(rx_cnt), 32'(n_pop));
        chk("rnd_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("rnd_fifo_drained", 32'(cnt4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
